// File: rtl/uart_fifo.sv
// CSR-mapped UART with TX/RX byte FIFOs, optional parity, 1/2 stop bits and a level IRQ.
// Serialiser and deserialiser run on a 16x oversampling tick from a programmable divisor.

module uart_fifo_buf #(
  parameter int aw = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  head,
  output logic [aw:0] level,
  output logic        full,
  output logic        empty
);
  localparam int depth = 1 << aw;

  logic [7:0]    mem [depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (aw+1)'(depth));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still accepted when a pop frees the slot this cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + aw'(1);
      if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
      if (do_push && !do_pop)      level <= level + (aw+1)'(1);
      else if (do_pop && !do_push) level <= level - (aw+1)'(1);
    end
  end
endmodule

module uart_fifo #(
  parameter logic [4:0] csr_addr = 5'h0,
  parameter int         clk_freq = 100000000,
  parameter int         baud     = 115200,
  parameter int         fifo_aw  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [14:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam logic [15:0] div_default = 16'(clk_freq / baud / 16);

  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [15:0] div_reg;
  logic [5:0]  ctrl_reg;
  logic        rx_ovf, tx_ovf, frame_err;
  logic        sel, wr, stat_wr;
  logic [2:0]  clr;
  logic [31:0] rd_data, stat;
  logic        unused_bits;

  logic [15:0] tick_cnt, div_eff;
  logic        tick;

  logic             tx_push, tx_pop, tx_full, tx_empty, tx_idle, tx_last_stop;
  logic [7:0]       tx_head;
  logic [fifo_aw:0] tx_level;
  tx_state_t        tx_state;
  logic [3:0]       tx_sub;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_par, tx_par_en, tx_two, tx_stop2;

  logic             rx_s1, rx_s2, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_head;
  logic [fifo_aw:0] rx_level;
  rx_state_t        rx_state;
  logic [3:0]       rx_sub;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift, rx_data;
  logic             rx_par_en, rx_par_odd, rx_par_bit, rx_push, rx_ferr;

  assign unused_bits = ^{csr_a[9:3], csr_di[31:16]};

  assign sel     = (csr_a[14:10] == csr_addr);
  assign wr      = sel && csr_we;
  assign stat_wr = wr && (csr_a[2:0] == 3'd2);
  assign tx_push = wr && (csr_a[2:0] == 3'd0);
  assign rx_pop  = stat_wr && csr_di[0];
  assign clr     = stat_wr ? csr_di[5:3] : 3'b000;

  assign div_eff = (div_reg == 16'd0) ? 16'd1 : div_reg;
  assign tick    = (tick_cnt == 16'd0);

  assign tx_last_stop = (tx_state == TX_STOP) && tick && (tx_sub == 4'd15) && (!tx_two || tx_stop2);
  assign tx_pop       = ((tx_state == TX_IDLE) || tx_last_stop) && !tx_empty;
  assign tx_idle      = tx_empty && (tx_state == TX_IDLE);

  uart_fifo_buf #(.aw(fifo_aw)) tx_fifo (
    .clk(sys_clk), .rst_n(sys_rst_n), .push(tx_push), .pop(tx_pop), .din(csr_di[7:0]),
    .head(tx_head), .level(tx_level), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo_buf #(.aw(fifo_aw)) rx_fifo (
    .clk(sys_clk), .rst_n(sys_rst_n), .push(rx_push), .pop(rx_pop), .din(rx_data),
    .head(rx_head), .level(rx_level), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) tick_cnt <= '0;
    else if (tick)  tick_cnt <= div_eff - 16'd1;
    else            tick_cnt <= tick_cnt - 16'd1;
  end

  // Frame format is captured when a byte is popped so CTRL edits only affect later frames.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state  <= TX_IDLE;
      tx_sub    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_par_en <= 1'b0;
      tx_two    <= 1'b0;
      tx_stop2  <= 1'b0;
      uart_tx   <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (!tx_empty) begin
          tx_shift  <= tx_head;
          tx_par    <= (^tx_head) ^ ctrl_reg[4];
          tx_par_en <= ctrl_reg[3];
          tx_two    <= ctrl_reg[5];
          tx_state  <= TX_WAIT;
        end
        TX_WAIT: if (tick) begin
          tx_state <= TX_START;
          tx_sub   <= '0;
          uart_tx  <= 1'b0;
        end
        TX_START, TX_DATA, TX_PARITY, TX_STOP: if (tick) begin
          tx_sub <= tx_sub + 4'd1;
          if (tx_sub == 4'd15) begin
            if (tx_state == TX_START) begin
              tx_state <= TX_DATA;
              tx_bit   <= '0;
              uart_tx  <= tx_shift[0];
            end else if (tx_state == TX_DATA) begin
              if (tx_bit == 3'd7) begin
                tx_stop2 <= 1'b0;
                tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                uart_tx  <= tx_par_en ? tx_par : 1'b1;
              end else begin
                tx_bit   <= tx_bit + 3'd1;
                tx_shift <= tx_shift >> 1;
                uart_tx  <= tx_shift[1];
              end
            end else if (tx_state == TX_PARITY) begin
              tx_stop2 <= 1'b0;
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else if (tx_two && !tx_stop2) begin
              tx_stop2 <= 1'b1;
            end else if (!tx_empty) begin
              tx_shift  <= tx_head;
              tx_par    <= (^tx_head) ^ ctrl_reg[4];
              tx_par_en <= ctrl_reg[3];
              tx_two    <= ctrl_reg[5];
              tx_state  <= TX_START;
              uart_tx   <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state   <= RX_IDLE;
      rx_sub     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_bit <= 1'b0;
      rx_push    <= 1'b0;
      rx_data    <= '0;
      rx_ferr    <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        RX_IDLE: if (!rx_s2) begin
          rx_state   <= RX_START;
          rx_sub     <= '0;
          rx_par_en  <= ctrl_reg[3];
          rx_par_odd <= ctrl_reg[4];
        end
        RX_START: if (tick) begin
          // A start bit that is high again at mid-bit was a glitch.
          if (rx_sub == 4'd7) begin
            rx_sub   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_sub <= rx_sub + 4'd1;
          end
        end
        RX_DATA, RX_PARITY, RX_STOP: if (tick) begin
          rx_sub <= rx_sub + 4'd1;
          if (rx_sub == 4'd15) begin
            if (rx_state == RX_DATA) begin
              rx_shift <= {rx_s2, rx_shift[7:1]};
              rx_bit   <= rx_bit + 3'd1;
              if (rx_bit == 3'd7) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
            end else if (rx_state == RX_PARITY) begin
              rx_par_bit <= rx_s2;
              rx_state   <= RX_STOP;
            end else begin
              if (!rx_s2 || (rx_par_en && (((^rx_shift) ^ rx_par_bit) != rx_par_odd))) begin
                rx_ferr <= 1'b1;
              end else begin
                rx_push <= 1'b1;
                rx_data <= rx_shift;
              end
              rx_state <= RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: if (rx_s2) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign stat = {8'd0, 8'(tx_level), 8'(rx_level), 2'b00, frame_err, tx_ovf, rx_ovf,
                 tx_idle, !tx_full, !rx_empty};

  always_comb begin
    rd_data = '0;
    case (csr_a[2:0])
      3'd0:    rd_data = {24'd0, rx_head};
      3'd1:    rd_data = {16'd0, div_reg};
      3'd2:    rd_data = stat;
      3'd3:    rd_data = {26'd0, ctrl_reg};
      default: rd_data = '0;
    endcase
  end

  // Flag updates: a new event in the same cycle as its write-one-to-clear keeps the flag set.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csr_do    <= '0;
      div_reg   <= div_default;
      ctrl_reg  <= '0;
      rx_ovf    <= 1'b0;
      tx_ovf    <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      csr_do <= sel ? rd_data : 32'd0;
      if (wr && csr_a[2:0] == 3'd1) div_reg  <= csr_di[15:0];
      if (wr && csr_a[2:0] == 3'd3) ctrl_reg <= csr_di[5:0];
      rx_ovf    <= (rx_push && rx_full && !rx_pop) || (rx_ovf && !clr[0]);
      tx_ovf    <= (tx_push && tx_full && !tx_pop) || (tx_ovf && !clr[1]);
      frame_err <= rx_ferr || (frame_err && !clr[2]);
      irq <= (ctrl_reg[0] && !rx_empty) || (ctrl_reg[1] && tx_empty) ||
             (ctrl_reg[2] && (rx_ovf || tx_ovf || frame_err));
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: CSR access, TX framing/back-to-back timing, overflow,
// RX parity/framing errors, RX overflow with simultaneous pop, and start-bit glitch rejection.

module tb_uart_fifo;
  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic [14:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq;
  logic        uart_rx;
  logic        uart_tx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] mon_q[$];
  int         mon_t[$];
  logic       mon_s[$];
  logic [7:0] mon_b;
  int         mon_t0;

  uart_fifo #(.fifo_aw(2)) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n), .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di),
    .csr_do(csr_do), .irq(irq), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial monitor on uart_tx for 8N1 frames at 16 clocks per bit.
  always begin
    @(negedge clk);
    if (sys_rst_n && uart_tx == 1'b0) begin
      mon_t0 = cyc;
      mon_b  = 8'h00;
      repeat (7) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        mon_b[i] = uart_tx;
      end
      repeat (16) @(negedge clk);
      mon_q.push_back(mon_b);
      mon_t.push_back(mon_t0);
      mon_s.push_back(uart_tx);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_a  = {12'd0, a};
    csr_di = d;
    csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [14:0] a, input logic [31:0] exp);
    csr_a  = a;
    csr_we = 1'b0;
    @(negedge clk);
    check(tag, csr_do, exp);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par, input int nstop);
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (16) @(negedge clk);
    end
    if (par_en) begin
      uart_rx = par;
      repeat (16) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (16 * nstop) @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 3000 && mon_q.size() < n; i++) @(negedge clk);
    check("tx_frame_count", 32'(mon_q.size()), 32'(n));
  endtask

  task automatic clear_mon();
    mon_q.delete();
    mon_t.delete();
    mon_s.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    csr_a = '0;
    csr_we = 1'b0;
    csr_di = '0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_csr_do", csr_do, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge clk);
    rd_check("rst_stat", 15'd2, 32'h0000_0006);
    rd_check("rst_div", 15'd1, 32'd54);
    rd_check("rst_ctrl", 15'd3, 32'd0);
    rd_check("bank_miss", 15'h0402, 32'd0);

    // Reset in the middle of a TX frame returns the line high immediately.
    csr_wr(3'd1, 32'd1);
    repeat (60) @(negedge clk);
    csr_wr(3'd0, 32'h00);
    repeat (60) @(negedge clk);
    check("tx_mid_frame_low", 32'(uart_tx), 32'd0);
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_tx", 32'(uart_tx), 32'd1);
    check("async_rst_csr_do", csr_do, 32'd0);
    @(negedge clk);
    @(negedge clk);
    sys_rst_n = 1'b1;
    rd_check("rst2_stat", 15'd2, 32'h0000_0006);
    rd_check("rst2_div", 15'd1, 32'd54);
    csr_wr(3'd1, 32'd1);
    repeat (250) @(negedge clk);
    clear_mon();

    // Two back-to-back 8N1 frames.
    csr_wr(3'd3, 32'd0);
    csr_wr(3'd0, 32'h55);
    csr_wr(3'd0, 32'hA3);
    rd_check("tx2_stat_level1", 15'd2, 32'h0001_0002);
    wait_frames(2);
    check("tx2_byte0", 32'(mon_q[0]), 32'h55);
    check("tx2_byte1", 32'(mon_q[1]), 32'hA3);
    check("tx2_stop0", 32'(mon_s[0]), 32'd1);
    check("tx2_stop1", 32'(mon_s[1]), 32'd1);
    check("tx2_gap", 32'(mon_t[1] - mon_t[0]), 32'd160);
    repeat (20) @(negedge clk);
    rd_check("tx2_idle_stat", 15'd2, 32'h0000_0006);
    csr_wr(3'd3, 32'h02);
    repeat (2) @(negedge clk);
    check("tx_irq_on", 32'(irq), 32'd1);
    csr_wr(3'd3, 32'h00);
    repeat (2) @(negedge clk);
    check("tx_irq_off", 32'(irq), 32'd0);
    clear_mon();

    // TX overflow: one byte in the shifter, four in the FIFO, the sixth is dropped.
    for (int i = 1; i <= 6; i++) csr_wr(3'd0, 32'(i));
    rd_check("tx_ovf_stat", 15'd2, 32'h0004_0010);
    csr_wr(3'd2, 32'h10);
    rd_check("tx_ovf_clr_stat", 15'd2, 32'h0004_0000);
    wait_frames(5);
    for (int i = 0; i < 5; i++) check($sformatf("tx_ovf_byte%0d", i), 32'(mon_q[i]), 32'(i + 1));
    repeat (20) @(negedge clk);
    rd_check("tx_ovf_idle_stat", 15'd2, 32'h0000_0006);
    clear_mon();

    // RX 8O2: 0x3C has four ones, so odd parity bit must be 1.
    csr_wr(3'd3, 32'h39);
    send_frame(8'h3C, 1'b1, 1'b0, 2);
    rd_check("rx_bad_par_stat", 15'd2, 32'h0000_0026);
    check("rx_bad_par_irq", 32'(irq), 32'd0);
    csr_wr(3'd2, 32'h20);
    rd_check("rx_ferr_clr_stat", 15'd2, 32'h0000_0006);
    send_frame(8'h3C, 1'b1, 1'b1, 2);
    rd_check("rx_good_stat", 15'd2, 32'h0000_0107);
    check("rx_good_irq", 32'(irq), 32'd1);
    rd_check("rx_good_data", 15'd0, 32'h3C);
    csr_wr(3'd2, 32'h01);
    rd_check("rx_pop_stat", 15'd2, 32'h0000_0006);
    @(negedge clk);
    check("rx_irq_off", 32'(irq), 32'd0);

    // RX overflow into a depth-4 FIFO.
    csr_wr(3'd3, 32'h00);
    for (int i = 1; i <= 5; i++) send_frame(8'(8'h11 * i), 1'b0, 1'b0, 1);
    rd_check("rx_ovf_stat", 15'd2, 32'h0000_040F);
    for (int i = 1; i <= 4; i++) begin
      rd_check($sformatf("rx_ovf_data%0d", i), 15'd0, 32'(8'h11 * i));
      csr_wr(3'd2, 32'h01);
    end
    rd_check("rx_ovf_drained", 15'd2, 32'h0000_000E);
    csr_wr(3'd2, 32'h08);
    rd_check("rx_ovf_clr", 15'd2, 32'h0000_0006);

    // Refill to full, then pop in the exact cycle the fifth byte is pushed.
    for (int i = 1; i <= 4; i++) send_frame(8'(8'h60 + i), 1'b0, 1'b0, 1);
    fork
      send_frame(8'h65, 1'b0, 1'b0, 1);
      begin
        repeat (155) @(negedge clk);
        csr_wr(3'd2, 32'h01);
      end
    join
    rd_check("rx_popush_stat", 15'd2, 32'h0000_0407);
    for (int i = 2; i <= 5; i++) begin
      rd_check($sformatf("rx_popush_data%0d", i), 15'd0, 32'(8'h60 + i));
      csr_wr(3'd2, 32'h01);
    end
    rd_check("rx_popush_empty", 15'd2, 32'h0000_0006);

    // Three-clock low glitch must not start a frame.
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    rd_check("glitch_stat", 15'd2, 32'h0000_0006);
    send_frame(8'h5A, 1'b0, 1'b0, 1);
    rd_check("post_glitch_stat", 15'd2, 32'h0000_0107);
    rd_check("post_glitch_data", 15'd0, 32'h5A);
    csr_wr(3'd2, 32'h01);
    rd_check("post_glitch_empty", 15'd2, 32'h0000_0006);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
